// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the D-stage hazard / stall controller.
// Holds the Tuse/Tnew encodings, the default MDU latencies and the
// register-zero constant used by the hazard comparators.
package hazard_stall_ctrl_pkg;

    // Tuse: cycles until the D instruction consumes a source register.
    localparam logic [1:0] TUSE_NOW  = 2'd0;
    localparam logic [1:0] TUSE_ONE  = 2'd1;
    localparam logic [1:0] TUSE_TWO  = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;   // source not read; never stalls

    // Tnew: cycles until an in-flight writer produces its result (max 2).
    localparam logic [1:0] TNEW_READY = 2'd0;
    localparam logic [1:0] TNEW_MAX   = 2'd2;

    // Default multiply/divide unit latencies and busy-counter width.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // $0 is hard-wired zero: a match on it is never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy counter.
// A start pulse loads the operation latency (reloading even when already
// busy); the counter then counts down to zero and holds there.
// o_busy is taken straight from the registered count, so the first busy
// cycle is the one after the start pulse.
module md_busy_cnt
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Load on start, otherwise count down to zero and stay there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_is_div ? LOAD_DIV : LOAD_MULT;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard detection and pipeline stall control.
// Compares the D instruction's source registers and Tuse against the
// E and M writers' destinations and Tnew, and holds a D-stage HI/LO
// instruction while the multiply/divide unit is busy.
//
// Control semantics: there is no handshake. Every output is valid in the
// same cycle as the inputs. When stall=1, PC and F/D hold (PC_en=FD_en=0)
// and D/E is cleared to a nop (DE_reset=1, which the D/E register gives
// priority over DE_en, so DE_en is simply tied high).
//
// Optional build macro STALL_STAT_EN adds saturating stall statistics
// outputs stall_cnt and md_stall_cnt.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_en,
    output logic        DE_reset,
    output logic        md_busy
`ifdef STALL_STAT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;
    logic w_stall;
    logic w_md_busy;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_start  (E_md_start),
        .i_is_div (E_md_is_div),
        .o_busy   (w_md_busy)
    );

    // A source stalls when a later stage will write it but its result
    // arrives later than the D instruction needs it.
    assign w_stall_rs = (D_rs != REG_ZERO) &&
                        (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                         ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));

    assign w_stall_rt = (D_rt != REG_ZERO) &&
                        (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                         ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));

    // The start cycle itself is covered by E_md_start; later cycles by the counter.
    assign w_stall_md = D_is_md && (E_md_start || w_md_busy);

    assign w_stall = w_stall_rs || w_stall_rt || w_stall_md;

    assign PC_en    = ~w_stall;
    assign FD_en    = ~w_stall;
    assign DE_en    = 1'b1;
    assign DE_reset = w_stall;
    assign md_busy  = w_md_busy;

`ifdef STALL_STAT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_md_stall_cnt;

    // Saturating count of all stall cycles and of MDU-caused stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt    <= '0;
            r_md_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_stall_md && (r_md_stall_cnt != '1)) begin
                r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt    = r_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed sequences plus randomized
// traffic, checked by a scoreboard against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  D_rs, D_rt, E_A3, M_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        D_is_md, E_md_start, E_md_is_div;
    logic        PC_en, FD_en, DE_en, DE_reset, md_busy;
`ifdef STALL_STAT_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    hazard_stall_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_is_md     (D_is_md),
        .E_A3        (E_A3),
        .E_Tnew      (E_Tnew),
        .M_A3        (M_A3),
        .M_Tnew      (M_Tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .PC_en       (PC_en),
        .FD_en       (FD_en),
        .DE_en       (DE_en),
        .DE_reset    (DE_reset),
        .md_busy     (md_busy)
`ifdef STALL_STAT_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    // ---------------- reference model ----------------
    // Time is an absolute cycle index. The MDU is busy in every cycle up to
    // and including busy_end; a start in cycle t makes it busy for t+1..t+N.
    int cyc       = 0;
    int busy_end  = -100;
    longint sc_model = 0;
    longint mc_model = 0;

    function automatic bit src_hazard(input logic [4:0] src, input logic [1:0] tuse);
        int need, e_ready, m_ready;
        need    = int'(tuse);
        e_ready = int'(E_Tnew);
        m_ready = int'(M_Tnew);
        if (src == 5'd0) return 1'b0;
        return ((src == E_A3) && (e_ready > need)) || ((src == M_A3) && (m_ready > need));
    endfunction

    function automatic bit model_md_stall(input bit busy);
        return D_is_md && (E_md_start || busy);
    endfunction

    function automatic bit model_stall(input bit busy);
        return src_hazard(D_rs, D_Tuse_rs) || src_hazard(D_rt, D_Tuse_rt) || model_md_stall(busy);
    endfunction

    // Apply the effect of the inputs that were present at the clock edge.
    task automatic model_edge();
        bit busy;
        busy = (cyc <= busy_end);
        if (reset) begin
            busy_end = cyc;
            sc_model = 0;
            mc_model = 0;
        end else begin
            if (model_stall(busy) && sc_model < 64'hFFFF_FFFF) sc_model++;
            if (model_md_stall(busy) && mc_model < 64'hFFFF_FFFF) mc_model++;
            if (E_md_start) busy_end = cyc + (E_md_is_div ? DIV_N : MULT_N);
        end
        cyc++;
    endtask

    // ---------------- scoreboard ----------------
    // Entry layout: {PC_en, FD_en, DE_en, DE_reset, md_busy, stall_cnt, md_stall_cnt}
    logic [68:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic push_expected();
        bit busy, st;
        logic [68:0] e;
        busy = (cyc <= busy_end);
        st   = model_stall(busy);
        e = {~st, ~st, 1'b1, st, busy, sc_model[31:0], mc_model[31:0]};
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst,
                         input logic [4:0] rs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic [1:0] tu_rt,
                         input logic md,
                         input logic [4:0] ea3, input logic [1:0] etn,
                         input logic [4:0] ma3, input logic [1:0] mtn,
                         input logic start, input logic isdiv);
        @(posedge clk);
        model_edge();
        #1;
        reset = rst;
        D_rs = rs;  D_Tuse_rs = tu_rs;
        D_rt = rt;  D_Tuse_rt = tu_rt;
        D_is_md = md;
        E_A3 = ea3; E_Tnew = etn;
        M_A3 = ma3; M_Tnew = mtn;
        E_md_start = start; E_md_is_div = isdiv;
        push_expected();
    endtask

    task automatic idle(input logic md);
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, md, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [68:0] e;
        logic [4:0]  got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {PC_en, FD_en, DE_en, DE_reset, md_busy};
            checks++;
            if (got !== e[68:64]) begin
                errors++;
                $display("FAIL ctl cyc=%0d got PC/FD/DE_en/DE_rst/busy=%b expected=%b", cyc, got, e[68:64]);
            end
`ifdef STALL_STAT_EN
            checks++;
            if ({stall_cnt, md_stall_cnt} !== e[63:0]) begin
                errors++;
                $display("FAIL stat cyc=%0d got stall_cnt=%0d md_stall_cnt=%0d expected %0d %0d",
                         cyc, stall_cnt, md_stall_cnt, e[63:32], e[31:0]);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 1'b0;
        E_A3 = '0; E_Tnew = '0; M_A3 = '0; M_Tnew = '0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state with all-zero inputs.
        drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(1'b0);

        // E-stage writer late for a Tuse=0 reader, then M writer ready.
        drive(1'b0, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 1'b0, 1'b0);
        // Register zero never stalls.
        drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0, 1'b0);
        // rt hazard against M, and Tuse=3 never stalls.
        drive(1'b0, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 5'd9, 2'd3, 5'd9, 2'd3, 1'b0, 5'd9, 2'd2, 5'd9, 2'd2, 1'b0, 1'b0);

        // mult start with a HI/LO reader held in D.
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        repeat (8) idle(1'b1);

        // div start, no HI/LO reader: busy only.
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        repeat (13) idle(1'b0);

        // div start, reset after 3 cycles.
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        repeat (3) idle(1'b1);
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) idle(1'b1);

        // mult restart while div still running reloads the counter.
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        repeat (2) idle(1'b0);
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        repeat (7) idle(1'b1);

        // Randomized traffic over a small register set so hazards are common.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain timeout: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
